// File: rtl/fft_bitrev_reorder.sv
// Output reorder stage of the 16-point FFT: takes bit-reversed I/Q frames into a ping-pong
// pair of banks and streams each completed frame out in natural bin order.
module fft_bitrev_reorder #(
    parameter int WORD_LENGTH = 8,
    parameter int N_POINTS    = 16,
    parameter int LOG2_N      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] i_in,
    input  logic [WORD_LENGTH-1:0] q_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] i_out,
    output logic [WORD_LENGTH-1:0] q_out,
    output logic [LOG2_N-1:0]      out_index,
    output logic                   out_last
);

    localparam int SAMPLE_W = 2 * WORD_LENGTH;
    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_POINTS - 1);
    localparam logic [LOG2_N-1:0] CNT_ZERO = {LOG2_N{1'b0}};
    localparam logic [LOG2_N-1:0] CNT_ONE  = {{(LOG2_N-1){1'b0}}, 1'b1};

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] idx);
        logic [LOG2_N-1:0] rev;
        rev = {LOG2_N{1'b0}};
        for (int b = 0; b < LOG2_N; b++) begin
            rev[b] = idx[LOG2_N-1-b];
        end
        return rev;
    endfunction

    logic [SAMPLE_W-1:0] mem_r [2*N_POINTS];
    logic [1:0]          bank_full_r;
    logic [1:0]          bank_full_nxt_s;
    logic [1:0]          set_full_s;
    logic [1:0]          clr_full_s;
    logic                wr_bank_r;
    logic                rd_bank_r;
    logic [LOG2_N-1:0]   wr_cnt_r;
    logic [LOG2_N-1:0]   rd_cnt_r;
    logic                accept_s;
    logic                load_s;
    logic                wr_wrap_s;
    logic                rd_wrap_s;
    logic [LOG2_N:0]     wr_addr_s;
    logic [LOG2_N:0]     rd_addr_s;
    logic [SAMPLE_W-1:0] rd_data_s;

    // Handshake decode and bank-full next state; a writer set and a reader clear never hit the same bank.
    always_comb begin
        in_ready        = !bank_full_r[wr_bank_r];
        accept_s        = in_valid && !bank_full_r[wr_bank_r];
        load_s          = bank_full_r[rd_bank_r] && (!out_valid || out_ready);
        wr_wrap_s       = accept_s && (wr_cnt_r == LAST_IDX);
        rd_wrap_s       = load_s && (rd_cnt_r == LAST_IDX);
        wr_addr_s       = {wr_bank_r, bitrev(wr_cnt_r)};
        rd_addr_s       = {rd_bank_r, rd_cnt_r};
        rd_data_s       = mem_r[rd_addr_s];
        set_full_s      = {wr_wrap_s && wr_bank_r, wr_wrap_s && !wr_bank_r};
        clr_full_s      = {rd_wrap_s && rd_bank_r, rd_wrap_s && !rd_bank_r};
        bank_full_nxt_s = (bank_full_r & ~clr_full_s) | set_full_s;
    end

    // Sample storage: scattered by bit-reversed index, no reset needed.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_addr_s] <= {i_in, q_in};
        end
    end

    // Write pointer, bank select and per-bank full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_r    <= CNT_ZERO;
            wr_bank_r   <= 1'b0;
            bank_full_r <= 2'b00;
        end else begin
            bank_full_r <= bank_full_nxt_s;
            if (wr_wrap_s) begin
                wr_cnt_r  <= CNT_ZERO;
                wr_bank_r <= !wr_bank_r;
            end else if (accept_s) begin
                wr_cnt_r <= wr_cnt_r + CNT_ONE;
            end
        end
    end

    // Single registered output slot, read sequentially from the full bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_r  <= CNT_ZERO;
            rd_bank_r <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= CNT_ZERO;
            i_out     <= {WORD_LENGTH{1'b0}};
            q_out     <= {WORD_LENGTH{1'b0}};
        end else if (load_s) begin
            i_out     <= rd_data_s[SAMPLE_W-1:WORD_LENGTH];
            q_out     <= rd_data_s[WORD_LENGTH-1:0];
            out_index <= rd_cnt_r;
            out_last  <= (rd_cnt_r == LAST_IDX);
            out_valid <= 1'b1;
            if (rd_wrap_s) begin
                rd_cnt_r  <= CNT_ZERO;
                rd_bank_r <= !rd_bank_r;
            end else begin
                rd_cnt_r <= rd_cnt_r + CNT_ONE;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
